v_hier_qvec_capture: RTL and testbench

- Sits directly downstream of the hierarchy sub-block and consumes its 4-bit `qvec` result bus.
- Samples `qvec` on qualified cycles and detects value changes.
- Timestamps each change and buffers it in a small FIFO.
- Presents buffered entries to a consumer through a valid/ready handshake, so bursts of `qvec` activity are not lost.

---
 rtl/v_hier_qvec_pkg.sv | 10 +
 rtl/v_hier_qvec_fifo.sv | 35 +++
 rtl/v_hier_qvec_capture.sv | 68 ++++++
 tb/tb_v_hier_qvec_capture.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/v_hier_qvec_pkg.sv
// v_hier_qvec_pkg: shared widths, entry layout and detector states for the qvec capture block
package v_hier_qvec_pkg;
  localparam int QVEC_W = 4;
  localparam int QVEC_TS_W = 8;
  typedef struct packed {
    logic [QVEC_W-1:0]    data;
    logic [QVEC_TS_W-1:0] ts;
  } qvec_entry_t;
  typedef enum logic {CAP_UNARMED, CAP_ARMED} cap_state_e;
endpackage

// File: rtl/v_hier_qvec_fifo.sv
// v_hier_qvec_fifo: DEPTH-entry FIFO, extra pointer MSB separates full from empty
module v_hier_qvec_fifo #(
  parameter int W = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // a pop on the same edge frees the slot being written when full
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/v_hier_qvec_capture.sv
// v_hier_qvec_capture: timestamps qvec changes into a FIFO with valid/ready output
// V_HIER_QVEC_OVF_CNT_EN adds a saturating dropped-change counter output ovf_cnt
module v_hier_qvec_capture
  import v_hier_qvec_pkg::*;
#(
  parameter int WIDTH = QVEC_W,
  parameter int DEPTH = 4,
  parameter int TS_W = QVEC_TS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] qvec,
  input  logic             clr_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TS_W-1:0]  out_ts,
  output logic             full,
  output logic             empty,
  output logic             overflow
`ifdef V_HIER_QVEC_OVF_CNT_EN
  ,
  output logic [7:0]       ovf_cnt
`endif
);
  cap_state_e state;
  logic [WIDTH-1:0] prev_q;
  logic [TS_W-1:0] ts;
  logic [WIDTH+TS_W-1:0] head;
  logic push, pop, drop;
  assign push = sample_en && (state == CAP_UNARMED || qvec != prev_q);
  assign pop = out_valid && out_ready;
  assign drop = push && full && !pop;
  assign out_valid = !empty;
  assign out_data = out_valid ? head[WIDTH+TS_W-1:TS_W] : '0;
  assign out_ts = out_valid ? head[TS_W-1:0] : '0;
  v_hier_qvec_fifo #(.W(WIDTH + TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({qvec, ts}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  // prev_q follows every sample, so a dropped value is not reported again
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CAP_UNARMED;
      prev_q <= '0;
      ts <= '0;
      overflow <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (sample_en) begin
        state <= CAP_ARMED;
        prev_q <= qvec;
      end
      overflow <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
    end
`ifdef V_HIER_QVEC_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_cnt <= '0;
    else ovf_cnt <= drop ? ovf_cnt + {7'd0, ovf_cnt != 8'hFF} : clr_ovf ? 8'd0 : ovf_cnt;
`endif
endmodule

// File: tb/tb_v_hier_qvec_capture.sv
// tb_v_hier_qvec_capture: directed and random stimulus against a queue-based reference model
module tb_v_hier_qvec_capture;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic sample_en = 0, clr_ovf = 0, out_ready = 0;
  logic [3:0] qvec = 0;
  logic out_valid, full, empty, overflow;
  logic [3:0] out_data;
  logic [7:0] out_ts;
`ifdef V_HIER_QVEC_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif
  int checks = 0, errors = 0;
  logic [11:0] mq[$];
  logic m_armed, m_ovf;
  logic [3:0] m_prev;
  logic [7:0] m_ts;
  int m_cnt;
  logic [3:0] saved;

  v_hier_qvec_capture dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .qvec(qvec), .clr_ovf(clr_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ts(out_ts),
    .full(full), .empty(empty), .overflow(overflow)
`ifdef V_HIER_QVEC_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_armed = 0;
    m_ovf = 0;
    m_prev = 0;
    m_ts = 0;
    m_cnt = 0;
  endtask

  task automatic check_all();
    check("out_valid", out_valid, mq.size() > 0);
    check("out_data", out_data, mq.size() > 0 ? mq[0][11:8] : 4'h0);
    check("out_ts", out_ts, mq.size() > 0 ? mq[0][7:0] : 8'h0);
    check("full", full, mq.size() == DEPTH);
    check("empty", empty, mq.size() == 0);
    check("overflow", overflow, m_ovf);
`ifdef V_HIER_QVEC_OVF_CNT_EN
    check("ovf_cnt", ovf_cnt, m_cnt);
`endif
  endtask

  // called at a falling edge: drive, predict the next rising edge, then check after it
  task automatic step(input logic se, input logic [3:0] q, input logic rdy, input logic clr);
    bit pop, req, drop;
    sample_en = se;
    qvec = se ? q : 4'hx;
    out_ready = rdy;
    clr_ovf = clr;
    pop = mq.size() > 0 && rdy;
    req = se && (!m_armed || q != m_prev);
    drop = req && mq.size() == DEPTH && !pop;
    if (se) begin
      m_armed = 1;
      m_prev = q;
    end
    if (pop) void'(mq.pop_front());
    if (req && !drop) mq.push_back({q, m_ts});
    if (drop) begin
      m_ovf = 1;
      if (m_cnt < 255) m_cnt++;
    end else if (clr) begin
      m_ovf = 0;
      m_cnt = 0;
    end
    m_ts++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;
    repeat (3) step(0, 0, 0, 0);
    step(1, 4'h5, 0, 0);
    check("first_data", out_data, 4'h5);
    check("first_ts", out_ts, 8'd3);
    repeat (10) step(1, 4'h5, 1, 0);
    check("hold_empty", empty, 1'b1);
    foreach (saved[i]) ;
    step(1, 4'h1, 0, 0);
    step(1, 4'h2, 0, 0);
    step(1, 4'h3, 0, 0);
    step(1, 4'h4, 0, 0);
    step(1, 4'h6, 0, 0);
    check("burst_full", full, 1'b1);
    check("burst_ovf", overflow, 1'b1);
    check("burst_head", out_data, 4'h1);
`ifdef V_HIER_QVEC_OVF_CNT_EN
    check("burst_cnt", ovf_cnt, 8'd1);
`endif
    step(1, 4'h7, 1, 0);
    check("pushpop_full", full, 1'b1);
    check("pushpop_ovf", overflow, 1'b1);
    check("pushpop_head", out_data, 4'h2);
    step(0, 0, 0, 1);
    check("clr_ovf", overflow, 1'b0);
    for (int i = 0; i < 300 && m_ts != 8'd255; i++) step(0, 0, 1, 0);
    repeat (DEPTH) step(0, 0, 1, 0);
    for (int i = 0; i < 300 && m_ts != 8'd255; i++) step(0, 0, 1, 0);
    check("empty_before_wrap", empty, 1'b1);
    step(1, m_prev ^ 4'h1, 0, 0);
    step(0, 0, 0, 0);
    step(1, m_prev ^ 4'h2, 0, 0);
    check("wrap_ts0", out_ts, 8'd255);
    step(0, 0, 1, 0);
    check("wrap_ts1", out_ts, 8'd1);
    step(0, 0, 1, 0);
    step(1, 4'h9, 0, 0);
    step(1, 4'hA, 0, 0);
    step(1, 4'hB, 0, 0);
    saved = m_prev;
    rst_n = 0;
    #1;
    check("rst_empty", empty, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1;
    step(1, saved, 0, 0);
    check("rearm_push", out_valid, 1'b1);
    check("rearm_data", out_data, saved);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
